// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer (BOOT/REQ/RSP/HOLD).
// Optional trap redirect input enabled by defining FETCH_CTRL_TRAP_EN.
module fetch_ctrl #(
  parameter int unsigned BOOT_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_out,
  output logic        pc_en,
  output logic        pc_load,
  output logic [31:0] pc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        decode_ready,
  input  logic        redirect_valid,
`ifdef FETCH_CTRL_TRAP_EN
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_vec
`else
  input  logic [31:0] redirect_pc
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    RSP,
    HOLD
  } state_t;

  localparam logic [7:0] BootLast = 8'(BOOT_WAIT - 1);

  state_t      state;
  logic [7:0]  boot_cnt;
  logic        pend_v;
  logic        pend_trap;
  logic [31:0] pend_pc;
  logic        drop;
  logic [31:0] req_addr;

  logic        rd_v;
  logic        rd_trap;
  logic [31:0] rd_pc;
  logic        take_new;
  logic        apply;
  logic        kill;
  logic [31:0] tgt;
  logic        unused_lsb;

  // Trap, when present, outranks a plain redirect.
  always_comb begin
`ifdef FETCH_CTRL_TRAP_EN
    rd_v    = redirect_valid | trap_valid;
    rd_trap = trap_valid;
    rd_pc   = trap_valid ? trap_vec : redirect_pc;
`else
    rd_v    = redirect_valid;
    rd_trap = 1'b0;
    rd_pc   = redirect_pc;
`endif
  end

  // A pending trap is never displaced by a plain redirect.
  assign take_new = rd_v && (rd_trap || !pend_trap);
  assign apply    = rd_v || pend_v;
  assign kill     = apply || drop;

  always_comb begin
    pc_en   = 1'b0;
    pc_load = 1'b0;
    tgt     = rd_pc;
    if (rst_n) begin
      unique case (state)
        BOOT: begin
          if (rd_v) begin
            pc_en   = 1'b1;
            pc_load = 1'b1;
          end
        end
        REQ: begin
        end
        RSP: begin
          if (apply) begin
            pc_en   = 1'b1;
            pc_load = 1'b1;
            tgt     = take_new ? rd_pc : pend_pc;
          end
        end
        HOLD: begin
          if (rd_v) begin
            pc_en   = 1'b1;
            pc_load = 1'b1;
          end else if (instr_valid && decode_ready) begin
            pc_en   = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pc_in      = {tgt[31:2], 2'b00};
  assign unused_lsb = ^tgt[1:0];
  assign imem_addr  = pc_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      boot_cnt    <= 8'd0;
      pend_v      <= 1'b0;
      pend_trap   <= 1'b0;
      pend_pc     <= 32'd0;
      drop        <= 1'b0;
      req_addr    <= 32'd0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
    end else begin
      unique case (state)
        BOOT: begin
          if (boot_cnt == BootLast) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + 8'd1;
          end
        end
        REQ: begin
          if (take_new) begin
            pend_v    <= 1'b1;
            pend_trap <= rd_trap;
            pend_pc   <= rd_pc;
          end
          if (imem_ack) begin
            state    <= RSP;
            imem_req <= 1'b0;
            req_addr <= pc_out;
          end
        end
        RSP: begin
          if (apply) begin
            pend_v    <= 1'b0;
            pend_trap <= 1'b0;
          end
          if (imem_rvalid) begin
            if (kill) begin
              state    <= REQ;
              imem_req <= 1'b1;
              drop     <= 1'b0;
            end else begin
              state       <= HOLD;
              instr       <= imem_rdata;
              instr_pc    <= req_addr;
              instr_valid <= 1'b1;
            end
          end else if (apply) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (rd_v || decode_ready) begin
            state       <= REQ;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Models the external PC register; builds with or without FETCH_CTRL_TRAP_EN.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_out;
  logic        pc_en;
  logic        pc_load;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_CTRL_TRAP_EN
  logic        trap_valid;
  logic [31:0] trap_vec;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_ctrl #(.BOOT_WAIT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_out(pc_out),
    .pc_en(pc_en),
    .pc_load(pc_load),
    .pc_in(pc_in),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .decode_ready(decode_ready),
    .redirect_valid(redirect_valid),
`ifdef FETCH_CTRL_TRAP_EN
    .redirect_pc(redirect_pc),
    .trap_valid(trap_valid),
    .trap_vec(trap_vec)
`else
    .redirect_pc(redirect_pc)
`endif
  );

  always #5 clk = ~clk;

  // External PC register driven by the DUT controls
  always @(posedge clk) begin
    if (!rst_n) pc_out <= 32'h0000_1000;
    else if (pc_en) pc_out <= pc_load ? pc_in : pc_out + 32'd4;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'd0;
    decode_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
`ifdef FETCH_CTRL_TRAP_EN
    trap_valid     = 1'b0;
    trap_vec       = 32'd0;
`endif
  endtask

  task automatic boot_to_req();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_8000;
    repeat (2) tick();
    n_cmp++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_req_valid: got req=%b vld=%b want 0/0", imem_req, instr_valid);
    end
    n_cmp++;
    if (pc_en !== 1'b0 || pc_load !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pc_ctrl: got en=%b ld=%b want 0/0", pc_en, pc_load);
    end
    n_cmp++;
    if (instr !== 32'd0 || instr_pc !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_boot();
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL boot_early: got req=%b want 0 after 3 cycles", imem_req);
    end
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin
      n_bad++;
      $display("FAIL boot_req: got req=%b addr=%h want 1/00001000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    int k = 0;
    int last = 0;
    imem_ack     = 1'b1;
    imem_rvalid  = 1'b1;
    decode_ready = 1'b1;
    imem_rdata   = 32'h0000_0013;
    for (int cyc = 0; cyc < 20 && k < 3; cyc++) begin
      tick();
      if (instr_valid) begin
        n_cmp++;
        if (instr_pc !== 32'h1000 + 32'(4 * k) || instr !== 32'h13 + 32'(k << 8)) begin
          n_bad++;
          $display("FAIL stream_pc%0d: got pc=%h ins=%h want %h/%h", k, instr_pc, instr,
                   32'h1000 + 32'(4 * k), 32'h13 + 32'(k << 8));
        end
        if (k > 0) begin
          n_cmp++;
          if (cyc - last !== 3) begin
            n_bad++;
            $display("FAIL stream_gap%0d: got %0d cycles want 3", k, cyc - last);
          end
        end
        last = cyc;
        k++;
        imem_rdata = 32'h13 + 32'(k << 8);
      end
    end
    imem_ack     = 1'b0;
    imem_rvalid  = 1'b0;
    decode_ready = 1'b0;
    n_cmp++;
    if (k !== 3) begin
      n_bad++;
      $display("FAIL stream_timeout: got %0d instrs want 3", k);
    end
  endtask

  task automatic test_redirect_handshake();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    decode_ready   = 1'b1;
    #1;
    n_cmp++;
    if (pc_en !== 1'b1 || pc_load !== 1'b1 || pc_in !== 32'h0000_3000) begin
      n_bad++;
      $display("FAIL rdr_hs_load: got en=%b ld=%b in=%h want 1/1/00003000", pc_en, pc_load, pc_in);
    end
    tick();
    redirect_valid = 1'b0;
    decode_ready   = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
      n_bad++;
      $display("FAIL rdr_hs_next: got vld=%b req=%b addr=%h want 0/1/00003000",
               instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_req();
    boot_to_req();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2002;
    #1;
    n_cmp++;
    if (pc_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rdr_req_noload: got en=%b want 0", pc_en);
    end
    tick();
    redirect_valid = 1'b0;
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin
      n_bad++;
      $display("FAIL rdr_req_hold: got req=%b addr=%h want 1/00001000", imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    #1;
    n_cmp++;
    if (pc_en !== 1'b1 || pc_load !== 1'b1 || pc_in !== 32'h0000_2000) begin
      n_bad++;
      $display("FAIL rdr_req_apply: got en=%b ld=%b in=%h want 1/1/00002000", pc_en, pc_load, pc_in);
    end
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin
      n_bad++;
      $display("FAIL rdr_req_drop: got vld=%b req=%b addr=%h want 0/1/00002000",
               instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_rvalid();
    imem_ack = 1'b1;
    tick();
    imem_ack       = 1'b0;
    imem_rvalid    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    #1;
    n_cmp++;
    if (pc_load !== 1'b1 || pc_in !== 32'h0000_5000) begin
      n_bad++;
      $display("FAIL rdr_rsp_load: got ld=%b in=%h want 1/00005000", pc_load, pc_in);
    end
    tick();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h0000_5000) begin
      n_bad++;
      $display("FAIL rdr_rsp_drop: got vld=%b addr=%h want 0/00005000", instr_valid, imem_addr);
    end
  endtask

  task automatic test_pending_overwrite();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_6000;
    tick();
    redirect_pc    = 32'h0000_7004;
    tick();
    redirect_valid = 1'b0;
    imem_ack       = 1'b1;
    tick();
    imem_ack    = 1'b0;
    imem_rvalid = 1'b1;
    #1;
    n_cmp++;
    if (pc_load !== 1'b1 || pc_in !== 32'h0000_7004) begin
      n_bad++;
      $display("FAIL pend_newest: got ld=%b in=%h want 1/00007004", pc_load, pc_in);
    end
    tick();
    imem_rvalid = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h0000_7004) begin
      n_bad++;
      $display("FAIL pend_next: got vld=%b addr=%h want 0/00007004", instr_valid, imem_addr);
    end
  endtask

  task automatic test_hold_stall();
    imem_ack = 1'b1;
    tick();
    imem_ack    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0093;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    tick();
    #1;
    n_cmp++;
    if (instr_valid !== 1'b1 || instr !== 32'h00A0_0093 || instr_pc !== 32'h0000_7004 ||
        pc_en !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_stall: got vld=%b ins=%h pc=%h en=%b want 1/00a00093/00007004/0",
               instr_valid, instr, instr_pc, pc_en);
    end
    decode_ready = 1'b1;
    #1;
    n_cmp++;
    if (pc_en !== 1'b1 || pc_load !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_adv: got en=%b ld=%b want 1/0", pc_en, pc_load);
    end
    tick();
    decode_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_7008) begin
      n_bad++;
      $display("FAIL hold_next: got req=%b addr=%h want 1/00007008", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_in_rsp();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_2222;
    repeat (3) tick();
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_rsp_boot: got vld=%b req=%b ins=%h want 0/0/0", instr_valid, imem_req, instr);
    end
    imem_rvalid = 1'b0;
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_rsp_fetch: got req=%b addr=%h vld=%b want 1/00001000/0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_boot_redirect();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_9003;
    #1;
    n_cmp++;
    if (pc_en !== 1'b1 || pc_load !== 1'b1 || pc_in !== 32'h0000_9000) begin
      n_bad++;
      $display("FAIL boot_rdr: got en=%b ld=%b in=%h want 1/1/00009000", pc_en, pc_load, pc_in);
    end
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_9000) begin
      n_bad++;
      $display("FAIL boot_rdr_req: got req=%b addr=%h want 1/00009000", imem_req, imem_addr);
    end
  endtask

`ifdef FETCH_CTRL_TRAP_EN
  task automatic test_trap_priority();
    boot_to_req();
    trap_valid     = 1'b1;
    trap_vec       = 32'h0000_0100;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    tick();
    trap_valid     = 1'b0;
    redirect_pc    = 32'h0000_4400;
    tick();
    redirect_valid = 1'b0;
    imem_ack       = 1'b1;
    tick();
    imem_ack    = 1'b0;
    imem_rvalid = 1'b1;
    #1;
    n_cmp++;
    if (pc_load !== 1'b1 || pc_in !== 32'h0000_0100) begin
      n_bad++;
      $display("FAIL trap_prio: got ld=%b in=%h want 1/00000100", pc_load, pc_in);
    end
    tick();
    imem_rvalid = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      n_bad++;
      $display("FAIL trap_next: got req=%b addr=%h want 1/00000100", imem_req, imem_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_boot();
    test_stream();
    test_redirect_handshake();
    test_redirect_req();
    test_redirect_rvalid();
    test_pending_overwrite();
    test_hold_stall();
    test_reset_in_rsp();
    test_boot_redirect();
`ifdef FETCH_CTRL_TRAP_EN
    test_trap_priority();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
